// File: rtl/prio_intr_controller.sv
// Priority interrupt controller: edge-captured pending bits, fixed or
// rotating arbitration, vector/EOI handshake over a shared 8-bit bus.
module prio_intr_controller #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] intr_rq,
   input  logic [N_SRC-1:0] mask,
   input  logic             mode,
   input  logic             intr_ack,
   output logic             intr_out,
   inout  wire  [7:0]       intr_bus,
   output logic             bus_oe,
   output logic [N_SRC-1:0] pending,
   output logic [ID_W-1:0]  active_id,
   output logic             err
);
   localparam logic [3:0] VEC_CODE = 4'b0101;
   localparam logic [3:0] EOI_CODE = 4'b1010;

   typedef enum logic [1:0] {IDLE, REQ, VEC, SVC} state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   rq_q, pending_q, pending_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    active_id_q, active_id_d;
   logic               intr_out_q, intr_out_d;
   logic               bus_oe_q, bus_oe_d;
   logic               err_q, err_d;
   logic [7:0]         bus_q, bus_d;
   logic [N_SRC-1:0]   elig, rot, set_v, clr_v;
   logic [2*N_SRC-1:0] dbl;
   logic [ID_W-1:0]    fix_win, rot_k, winner;
   logic [ID_W:0]      rot_sum, ptr_inc;

   function automatic logic [ID_W-1:0] lowest(input logic [N_SRC-1:0] v);
      logic [ID_W-1:0] r;
      r = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) r = ID_W'(i);
      end
      return r;
   endfunction

   // Rotating search: rotate eligible set so ptr lands on bit 0.
   always_comb begin
      elig    = pending_q & ~mask;
      dbl     = {elig, elig};
      rot     = N_SRC'(dbl >> ptr_q);
      fix_win = lowest(elig);
      rot_k   = lowest(rot);
      rot_sum = {1'b0, ptr_q} + {1'b0, rot_k};
      if (rot_sum >= (ID_W+1)'(N_SRC)) begin
         rot_sum = rot_sum - (ID_W+1)'(N_SRC);
      end
      winner  = mode ? rot_sum[ID_W-1:0] : fix_win;
      ptr_inc = {1'b0, winner} + (ID_W+1)'(1);
      if (ptr_inc == (ID_W+1)'(N_SRC)) begin
         ptr_inc = '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      active_id_d = active_id_q;
      bus_d       = bus_q;
      err_d       = err_q;
      clr_v       = '0;
      set_v       = intr_rq & ~rq_q;
      case (state_q)
         IDLE: begin
            if (|elig) state_d = REQ;
         end
         REQ: begin
            if (!(|elig)) begin
               state_d = IDLE;
            end else if (intr_ack) begin
               state_d     = VEC;
               active_id_d = winner;
               clr_v       = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
               bus_d       = {VEC_CODE, winner};
               if (mode) ptr_d = ptr_inc[ID_W-1:0];
            end
         end
         VEC: begin
            if (intr_ack) state_d = SVC;
         end
         SVC: begin
            if (intr_ack) begin
               if (intr_bus != {EOI_CODE, active_id_q}) err_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A new edge overrides a same-cycle clear.
      pending_d  = (pending_q & ~clr_v) | set_v;
      intr_out_d = (state_d == REQ);
      bus_oe_d   = (state_d == VEC);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rq_q        <= '0;
         pending_q   <= '0;
         ptr_q       <= '0;
         active_id_q <= '0;
         intr_out_q  <= 1'b0;
         bus_oe_q    <= 1'b0;
         err_q       <= 1'b0;
         bus_q       <= '0;
      end else begin
         state_q     <= state_d;
         rq_q        <= intr_rq;
         pending_q   <= pending_d;
         ptr_q       <= ptr_d;
         active_id_q <= active_id_d;
         intr_out_q  <= intr_out_d;
         bus_oe_q    <= bus_oe_d;
         err_q       <= err_d;
         bus_q       <= bus_d;
      end
   end

   assign intr_bus  = bus_oe_q ? bus_q : 8'bz;
   assign intr_out  = intr_out_q;
   assign bus_oe    = bus_oe_q;
   assign pending   = pending_q;
   assign active_id = active_id_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prio_intr_controller.sv
// Bench for prio_intr_controller: vector table, directed corner
// sequences and randomized rounds against a transaction-level model.
module tb_prio_intr_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] intr_rq;
   logic [7:0] mask;
   logic       mode;
   logic       intr_ack;
   logic       intr_out;
   wire  [7:0] intr_bus;
   logic       bus_oe;
   logic [7:0] pending;
   logic [3:0] active_id;
   logic       err;
   logic       tb_drv;
   logic [7:0] tb_val;

   int n_pass = 0;
   int n_total = 0;

   assign intr_bus = tb_drv ? tb_val : 8'bz;

   prio_intr_controller #(.N_SRC(8), .ID_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .intr_rq   (intr_rq),
      .mask      (mask),
      .mode      (mode),
      .intr_ack  (intr_ack),
      .intr_out  (intr_out),
      .intr_bus  (intr_bus),
      .bus_oe    (bus_oe),
      .pending   (pending),
      .active_id (active_id),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rq;
      logic [7:0] msk;
      logic       md;
      logic [7:0] pend;
      logic       out;
      logic [7:0] vec;
      logic [7:0] pend_after;
   } vec_t;

   vec_t tbl[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      intr_rq  = '0;
      mask     = '0;
      mode     = 1'b0;
      intr_ack = 1'b0;
      tb_drv   = 1'b0;
      tb_val   = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] r);
      intr_rq = r;
      step();
      intr_rq = '0;
   endtask

   task automatic ack();
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
   endtask

   task automatic eoi(input logic [7:0] v);
      tb_drv   = 1'b1;
      tb_val   = v;
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      tb_drv   = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (intr_out !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("intr_out_wait", intr_out, 1'b1);
   endtask

   // Spec rule: first set index searching upward from start, wrapping.
   function automatic int pick(input logic [7:0] e, input logic md,
                               input int p);
      int start;
      int idx;
      start = md ? p : 0;
      for (int k = 0; k < 8; k++) begin
         idx = (start + k) % 8;
         if (e[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] m_pend;
      logic [7:0] r;
      logic [7:0] e;
      logic [7:0] v;
      int         m_ptr;
      int         w;
      logic       m_err;
      logic       bad;

      tbl[0] = '{8'h24, 8'h00, 1'b0, 8'h24, 1'b1, 8'h52, 8'h20};
      tbl[1] = '{8'h81, 8'h01, 1'b0, 8'h81, 1'b1, 8'h57, 8'h01};
      tbl[2] = '{8'h0A, 8'h00, 1'b1, 8'h0A, 1'b1, 8'h51, 8'h08};
      tbl[3] = '{8'h01, 8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 8'h01};
      tbl[4] = '{8'hF0, 8'h30, 1'b1, 8'hF0, 1'b1, 8'h56, 8'hB0};
      tbl[5] = '{8'hFF, 8'hFE, 1'b0, 8'hFF, 1'b1, 8'h50, 8'hFE};

      do_reset();
      chk("rst_intr_out", intr_out, 1'b0);
      chk("rst_bus_oe", bus_oe, 1'b0);
      chk("rst_pending", pending, 8'h00);
      chk("rst_active_id", active_id, 4'h0);
      chk("rst_err", err, 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         mask    = tbl[i].msk;
         mode    = tbl[i].md;
         intr_rq = tbl[i].rq;
         step();
         intr_rq = '0;
         chk($sformatf("tbl%0d_pend", i), pending, tbl[i].pend);
         chk($sformatf("tbl%0d_out_early", i), intr_out, 1'b0);
         step();
         chk($sformatf("tbl%0d_out", i), intr_out, tbl[i].out);
         if (tbl[i].out) begin
            ack();
            chk($sformatf("tbl%0d_vec", i), intr_bus, tbl[i].vec);
            chk($sformatf("tbl%0d_oe", i), bus_oe, 1'b1);
            chk($sformatf("tbl%0d_out_drop", i), intr_out, 1'b0);
         end
         chk($sformatf("tbl%0d_pend_after", i), pending, tbl[i].pend_after);
      end

      // Fixed mode two-round service with good EOI
      do_reset();
      pulse(8'h24);
      step();
      chk("fix_out", intr_out, 1'b1);
      ack();
      chk("fix_vec1", intr_bus, 8'h52);
      chk("fix_pend1", pending, 8'h20);
      ack();
      chk("fix_oe_svc", bus_oe, 1'b0);
      eoi(8'hA2);
      chk("fix_err", err, 1'b0);
      wait_out();
      ack();
      chk("fix_vec2", intr_bus, 8'h55);
      chk("fix_pend2", pending, 8'h00);

      // Rotating mode with re-raised source
      do_reset();
      mode = 1'b1;
      pulse(8'h0A);
      wait_out();
      ack();
      chk("rot_vec1", intr_bus, 8'h51);
      ack();
      pulse(8'h02);
      chk("rot_pend_svc", pending, 8'h0A);
      eoi(8'hA1);
      wait_out();
      ack();
      chk("rot_vec2", intr_bus, 8'h53);
      ack();
      eoi(8'hA3);
      wait_out();
      ack();
      chk("rot_vec3", intr_bus, 8'h51);
      chk("rot_err", err, 1'b0);

      // Masked source, then unmask
      do_reset();
      mask = 8'h01;
      pulse(8'h01);
      step();
      step();
      chk("msk_out", intr_out, 1'b0);
      chk("msk_pend", pending, 8'h01);
      mask = 8'h00;
      step();
      chk("msk_unmask_out", intr_out, 1'b1);

      // Bad EOI is sticky and returns to IDLE
      do_reset();
      pulse(8'h04);
      wait_out();
      ack();
      ack();
      eoi(8'hA7);
      chk("bad_err", err, 1'b1);
      chk("bad_oe", bus_oe, 1'b0);
      chk("bad_out", intr_out, 1'b0);
      pulse(8'h01);
      step();
      chk("bad_idle_out", intr_out, 1'b1);
      ack();
      ack();
      eoi(8'hA0);
      chk("bad_sticky", err, 1'b1);

      // Reset asserted in VEC releases bus without a clock edge
      do_reset();
      pulse(8'h04);
      wait_out();
      ack();
      chk("arst_pre_oe", bus_oe, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("arst_oe", bus_oe, 1'b0);
      chk("arst_out", intr_out, 1'b0);
      chk("arst_id", active_id, 4'h0);
      chk("arst_pend", pending, 8'h00);
      chk("arst_err", err, 1'b0);
      step();
      reset = 1'b0;
      step();
      step();
      chk("arst_post_out", intr_out, 1'b0);

      // Mask covering all pending while in REQ
      do_reset();
      pulse(8'h06);
      step();
      chk("rqm_out", intr_out, 1'b1);
      mask = 8'h06;
      step();
      chk("rqm_drop", intr_out, 1'b0);
      chk("rqm_pend", pending, 8'h06);
      ack();
      chk("rqm_no_vec", bus_oe, 1'b0);
      chk("rqm_pend2", pending, 8'h06);
      mask = 8'h00;
      wait_out();

      // Source held high through reset release
      reset   = 1'b1;
      intr_rq = 8'h10;
      mask    = '0;
      mode    = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("hold_rst_pend", pending, 8'h00);
      step();
      chk("hold_pend", pending, 8'h10);
      step();
      chk("hold_out", intr_out, 1'b1);
      intr_rq = '0;

      // Randomized rounds against the transaction model
      do_reset();
      m_pend = '0;
      m_ptr  = 0;
      m_err  = 1'b0;
      for (int rnd = 0; rnd < 40; rnd++) begin
         mode    = 1'($urandom_range(0, 1));
         mask    = 8'($urandom & $urandom);
         r       = 8'($urandom_range(0, 255));
         pulse(r);
         m_pend = m_pend | r;
         chk($sformatf("rnd%0d_pend", rnd), pending, m_pend);
         e = m_pend & ~mask;
         if (e == 8'h00) begin
            step();
            step();
            chk($sformatf("rnd%0d_quiet", rnd), intr_out, 1'b0);
         end else begin
            wait_out();
            w = pick(e, mode, m_ptr);
            ack();
            chk($sformatf("rnd%0d_vec", rnd), intr_bus, {4'h5, 4'(w)});
            chk($sformatf("rnd%0d_oe", rnd), bus_oe, 1'b1);
            chk($sformatf("rnd%0d_id", rnd), active_id, 4'(w));
            m_pend[w] = 1'b0;
            if (mode) m_ptr = (w + 1) % 8;
            chk($sformatf("rnd%0d_pclr", rnd), pending, m_pend);
            ack();
            chk($sformatf("rnd%0d_oe_off", rnd), bus_oe, 1'b0);
            bad = ($urandom_range(0, 3) == 0);
            v   = {4'hA, 4'(w)};
            if (bad) v = v ^ (8'h01 << $urandom_range(0, 7));
            eoi(v);
            m_err = m_err | bad;
            chk($sformatf("rnd%0d_err", rnd), err, m_err);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
